// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: boots, then steers the next-PC mux and pipeline
// flushes from branch/jump/stall/memory-ready, and keeps redirect and stall counters.
module fetch_sequencer #(
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branchTaken,
  input  logic        jump,
  input  logic        hazardStall,
  input  logic        imemReady,
  input  logic        clearCounters,
  output logic        pcFlush,
  output logic        outputBrachControl,
  output logic        jumpSelect,
  output logic        ifidFlush,
  output logic        idexFlush,
  output logic        imemRequest,
  output logic [1:0]  fetchState,
  output logic [15:0] redirectCount,
  output logic [15:0] stallCount
);

  typedef enum logic [1:0] {
    StBoot     = 2'd0,
    StFetch    = 2'd1,
    StWaitMem  = 2'd2,
    StRedirect = 2'd3
  } state_e;

  localparam logic [3:0] BootLoad = 4'(BOOT_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [15:0] redirect_cnt_q, stall_cnt_q;
  logic        redirect_inc, stall_inc;

  always_comb begin
    state_d            = state_q;
    boot_cnt_d         = boot_cnt_q;
    pcFlush            = 1'b0;
    outputBrachControl = 1'b0;
    jumpSelect         = 1'b0;
    ifidFlush          = 1'b0;
    idexFlush          = 1'b0;
    imemRequest        = (state_q != StBoot);
    unique case (state_q)
      StBoot: begin
        pcFlush    = 1'b1;
        boot_cnt_d = boot_cnt_q - 4'd1;
        // FETCH is entered on the edge where the down-counter reaches zero.
        if (boot_cnt_q <= 4'd1) begin
          boot_cnt_d = 4'd0;
          state_d    = StFetch;
        end
      end
      StFetch: begin
        if (branchTaken) begin
          outputBrachControl = 1'b1;
          ifidFlush          = 1'b1;
          idexFlush          = 1'b1;
          state_d            = StRedirect;
        end else if (jump) begin
          jumpSelect = 1'b1;
          ifidFlush  = 1'b1;
          state_d    = StRedirect;
        end else if (hazardStall) begin
          pcFlush   = 1'b1;
          idexFlush = 1'b1;
        end else if (!imemReady) begin
          pcFlush = 1'b1;
          state_d = StWaitMem;
        end
      end
      StWaitMem: begin
        // A taken branch abandons the outstanding fetch; jump/stall are ignored.
        if (branchTaken) begin
          outputBrachControl = 1'b1;
          ifidFlush          = 1'b1;
          idexFlush          = 1'b1;
          state_d            = StRedirect;
        end else if (!imemReady) begin
          pcFlush   = 1'b1;
          ifidFlush = 1'b1;
        end else begin
          state_d = StFetch;
        end
      end
      StRedirect: begin
        if (branchTaken) begin
          outputBrachControl = 1'b1;
          ifidFlush          = 1'b1;
          idexFlush          = 1'b1;
        end else if (!imemReady) begin
          pcFlush = 1'b1;
          state_d = StWaitMem;
        end else begin
          state_d = StFetch;
        end
      end
    endcase
  end

  assign redirect_inc = outputBrachControl | jumpSelect;
  assign stall_inc    = (state_q != StBoot) & pcFlush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StBoot;
      boot_cnt_q     <= BootLoad;
      redirect_cnt_q <= 16'd0;
      stall_cnt_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      if (clearCounters) begin
        redirect_cnt_q <= 16'd0;
        stall_cnt_q    <= 16'd0;
      end else begin
        if (redirect_inc && (redirect_cnt_q != 16'hFFFF)) redirect_cnt_q <= redirect_cnt_q + 16'd1;
        if (stall_inc && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign fetchState    = state_q;
  assign redirectCount = redirect_cnt_q;
  assign stallCount    = stall_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the driver pushes hand-computed expectations per
// cycle, the monitor pops and compares them at the falling edge of that same cycle.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        branchTaken = 1'b0, jump = 1'b0, hazardStall = 1'b0;
  logic        imemReady = 1'b1, clearCounters = 1'b0;
  logic        pcFlush, outputBrachControl, jumpSelect, ifidFlush, idexFlush, imemRequest;
  logic [1:0]  fetchState;
  logic [15:0] redirectCount, stallCount;

  typedef struct {
    logic [5:0]  ctl;  // {pcFlush, brc, jumpSelect, ifidFlush, idexFlush, imemRequest}
    logic [1:0]  st;
    logic        chk;
    logic [15:0] rc;
    logic [15:0] sc;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  fetch_sequencer #(.BOOT_CYCLES(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .branchTaken       (branchTaken),
    .jump              (jump),
    .hazardStall       (hazardStall),
    .imemReady         (imemReady),
    .clearCounters     (clearCounters),
    .pcFlush           (pcFlush),
    .outputBrachControl(outputBrachControl),
    .jumpSelect        (jumpSelect),
    .ifidFlush         (ifidFlush),
    .idexFlush         (idexFlush),
    .imemRequest       (imemRequest),
    .fetchState        (fetchState),
    .redirectCount     (redirectCount),
    .stallCount        (stallCount)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic rst_mid, input logic br, input logic jmp,
                      input logic haz, input logic rdy, input logic clr, input logic [5:0] ctl,
                      input logic [1:0] st, input logic chk, input logic [15:0] rc,
                      input logic [15:0] sc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; branchTaken = br; jump = jmp; hazardStall = haz;
    imemReady = rdy; clearCounters = clr;
    e.ctl = ctl; e.st = st; e.chk = chk; e.rc = rc; e.sc = sc; e.id = step_id;
    step_id++;
    exp_q.push_back(e);
    if (rst_mid) begin
      #2 reset = 1'b0;
    end
  endtask

  // Monitor: compares whenever an expectation is pending for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({pcFlush, outputBrachControl, jumpSelect, ifidFlush, idexFlush, imemRequest}
            !== e.ctl) begin
          errors++;
          $display("FAIL step%0d ctl: got %b want %b", e.id,
                   {pcFlush, outputBrachControl, jumpSelect, ifidFlush, idexFlush, imemRequest},
                   e.ctl);
        end
        checks++;
        if (fetchState !== e.st) begin
          errors++;
          $display("FAIL step%0d fetchState: got %0d want %0d", e.id, fetchState, e.st);
        end
        if (e.chk) begin
          checks++;
          if (redirectCount !== e.rc) begin
            errors++;
            $display("FAIL step%0d redirectCount: got %h want %h", e.id, redirectCount, e.rc);
          end
          checks++;
          if (stallCount !== e.sc) begin
            errors++;
            $display("FAIL step%0d stallCount: got %h want %h", e.id, stallCount, e.sc);
          end
        end
      end
    end
  end

  initial begin
    //   rst mid br jmp haz rdy clr  ctl       st chk rc      sc
    step(0, 0, 0, 0, 0, 1, 0, 6'b100000, 0, 1, 16'd0, 16'd0);  // held in reset
    step(1, 0, 0, 0, 0, 1, 0, 6'b100000, 0, 0, 16'd0, 16'd0);  // boot cycle 1
    step(1, 0, 0, 0, 0, 1, 0, 6'b100000, 0, 0, 16'd0, 16'd0);  // boot cycle 2
    step(1, 0, 0, 0, 0, 1, 0, 6'b000001, 1, 1, 16'd0, 16'd0);  // first FETCH
    step(1, 0, 1, 1, 0, 1, 0, 6'b010111, 1, 0, 16'd0, 16'd0);  // branch beats jump
    step(1, 0, 0, 1, 1, 1, 0, 6'b000001, 3, 1, 16'd1, 16'd0);  // REDIRECT ignores jmp/haz
    step(1, 0, 0, 1, 0, 1, 0, 6'b001101, 1, 0, 16'd0, 16'd0);  // jump
    step(1, 0, 0, 0, 0, 0, 0, 6'b100001, 3, 0, 16'd0, 16'd0);  // REDIRECT, mem not ready
    step(1, 0, 0, 0, 0, 0, 0, 6'b100101, 2, 1, 16'd2, 16'd1);  // WAIT_MEM
    step(1, 0, 0, 1, 1, 1, 0, 6'b000001, 2, 0, 16'd0, 16'd0);  // WAIT_MEM ready, jump ignored
    step(1, 0, 0, 0, 1, 1, 0, 6'b100011, 1, 1, 16'd2, 16'd2);  // hazard stall
    step(1, 0, 0, 0, 0, 0, 0, 6'b100001, 1, 1, 16'd2, 16'd3);  // FETCH, mem not ready
    step(1, 0, 0, 0, 0, 0, 0, 6'b100101, 2, 0, 16'd0, 16'd0);
    step(1, 0, 0, 0, 0, 0, 0, 6'b100101, 2, 0, 16'd0, 16'd0);
    step(1, 0, 0, 0, 0, 0, 0, 6'b100101, 2, 0, 16'd0, 16'd0);
    step(1, 0, 0, 0, 0, 1, 0, 6'b000001, 2, 1, 16'd2, 16'd7);  // entry + 3 waits counted
    step(1, 0, 0, 0, 0, 1, 0, 6'b000001, 1, 1, 16'd2, 16'd7);
    step(1, 0, 0, 0, 0, 0, 0, 6'b100001, 1, 0, 16'd0, 16'd0);
    step(1, 0, 1, 0, 0, 0, 0, 6'b010111, 2, 0, 16'd0, 16'd0);  // branch overrides wait
    step(1, 0, 0, 1, 0, 1, 0, 6'b000001, 3, 1, 16'd3, 16'd8);  // jump ignored in REDIRECT
    step(1, 0, 1, 0, 0, 1, 0, 6'b010111, 1, 0, 16'd0, 16'd0);
    step(1, 0, 1, 0, 0, 1, 0, 6'b010111, 3, 0, 16'd0, 16'd0);  // branch in REDIRECT
    step(1, 0, 0, 0, 0, 1, 0, 6'b000001, 3, 1, 16'd5, 16'd8);
    step(1, 0, 0, 0, 1, 1, 1, 6'b100011, 1, 0, 16'd0, 16'd0);  // clear beats increment
    step(1, 0, 0, 0, 0, 1, 0, 6'b000001, 1, 1, 16'd0, 16'd0);
    repeat (65535) begin
      @(posedge clk);
      #1 hazardStall = 1'b1; imemReady = 1'b1;
    end
    step(1, 0, 0, 0, 1, 1, 0, 6'b100011, 1, 1, 16'd0, 16'hFFFF);
    step(1, 0, 0, 0, 0, 1, 0, 6'b000001, 1, 1, 16'd0, 16'hFFFF);  // saturated
    step(1, 0, 0, 0, 1, 1, 1, 6'b100011, 1, 1, 16'd0, 16'hFFFF);
    step(1, 0, 0, 0, 0, 1, 0, 6'b000001, 1, 1, 16'd0, 16'd0);
    step(1, 0, 0, 0, 0, 0, 0, 6'b100001, 1, 0, 16'd0, 16'd0);
    step(1, 1, 0, 0, 0, 0, 0, 6'b100000, 0, 1, 16'd0, 16'd0);  // async reset in WAIT_MEM
    step(0, 0, 0, 0, 0, 1, 0, 6'b100000, 0, 1, 16'd0, 16'd0);
    step(1, 0, 0, 0, 0, 1, 0, 6'b100000, 0, 0, 16'd0, 16'd0);
    step(1, 0, 0, 0, 0, 1, 0, 6'b100000, 0, 0, 16'd0, 16'd0);
    step(1, 0, 0, 0, 0, 1, 0, 6'b000001, 1, 1, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
